// File: rtl/sam_vram_pkg.sv
// Shared types for the CPU-side VRAM write path.
package sam_vram_pkg;

    localparam int unsigned VWR_AW = 19;
    localparam int unsigned VWR_DW = 8;
    localparam logic [2:0]  CPU_SLOT = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } vwr_state_t;

    typedef struct packed {
        logic [VWR_AW-1:0] addr;
        logic [VWR_DW-1:0] data;
    } vwr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO of pending CPU writes, with a flat view of all slots for forwarding.
module vram_wr_fifo
    import sam_vram_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   push,
    input  vwr_entry_t             push_entry,
    input  logic                   pop,
    output vwr_entry_t             head,
    output logic [CW-1:0]          count,
    output logic [PW-1:0]          rd_ptr,
    output logic                   full_c,
    output vwr_entry_t [DEPTH-1:0] entries
);

    vwr_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]          wr_ptr;
    logic                   push_ok;
    logic                   pop_ok;

    // Full is taken from the registered count, so a pop in the same cycle never frees room for a push.
    assign full_c  = (count == CW'(DEPTH));
    assign push_ok = push & ~full_c;
    assign pop_ok  = pop & (count != '0);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/vram_write_port.sv
// CPU write buffer into VRAM: queues byte writes and commits them only in CPU memory slots.
module vram_write_port
    import sam_vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = VWR_AW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_6mn,
    input  logic          slot_free,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    input  logic          cpu_rd,
    output logic          cpu_wait,
    output logic          fwd_hit,
    output logic [7:0]    fwd_data,
    output logic [AW-1:0] vram_waddr,
    output logic [7:0]    vram_wdata,
    output logic          vram_we,
    input  logic          vram_ack,
    output logic          ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [1:0]             rst_sync;
    logic                   rst_n_i;
    logic                   old_we;
    logic                   push_c;
    logic                   pop_c;
    logic                   full_c;
    vwr_entry_t             push_entry;
    vwr_entry_t             head;
    logic [CW-1:0]          count;
    logic [PW-1:0]          rd_ptr;
    vwr_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]          fwd_idx;

    vwr_state_t             state;
    vwr_state_t             state_nxt;
    logic                   we_nxt;
    logic [AW-1:0]          waddr_nxt;
    logic [7:0]             wdata_nxt;

    // Reset asserts immediately and releases on a clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n_i = rst_sync[1];

    // Write strobe edge detect and sticky overflow on a dropped push.
    always_ff @(posedge clk_sys or negedge rst_n_i) begin
        if (!rst_n_i) begin
            old_we <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            old_we <= cpu_we;
            if (push_c && full_c) begin
                ovf <= 1'b1;
            end
        end
    end

    assign push_c          = cpu_we & ~old_we;
    assign push_entry.addr = VWR_AW'(cpu_addr);
    assign push_entry.data = cpu_din;
    assign cpu_wait        = (count == CW'(DEPTH));

    vram_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset_n    (rst_n_i),
        .push       (push_c),
        .push_entry (push_entry),
        .pop        (pop_c),
        .head       (head),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .full_c     (full_c),
        .entries    (entries)
    );

    // Commit FSM state and registered VRAM request outputs.
    always_ff @(posedge clk_sys or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
        end else begin
            state      <= state_nxt;
            vram_we    <= we_nxt;
            vram_waddr <= waddr_nxt;
            vram_wdata <= wdata_nxt;
        end
    end

    // Next state: grab a free slot, hold the request until ack, then sit out the rest of the slot.
    always_comb begin
        state_nxt = state;
        we_nxt    = vram_we;
        waddr_nxt = vram_waddr;
        wdata_nxt = vram_wdata;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (ce_6mn && slot_free && (count != '0)) begin
                    state_nxt = REQ;
                    we_nxt    = 1'b1;
                    waddr_nxt = AW'(head.addr);
                    wdata_nxt = head.data;
                end
            end
            REQ: begin
                if (vram_ack) begin
                    state_nxt = DONE;
                    we_nxt    = 1'b0;
                    pop_c     = 1'b1;
                end
            end
            DONE: begin
                if (ce_6mn) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                we_nxt    = 1'b0;
            end
        endcase
    end

    // Read forwarding: scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (cpu_rd) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                fwd_idx = rd_ptr + PW'(k);
                if ((CW'(k) < count) && (entries[fwd_idx].addr == VWR_AW'(cpu_addr))) begin
                    fwd_hit  = 1'b1;
                    fwd_data = entries[fwd_idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_write_port.sv
// Directed bench for vram_write_port.
module tb_vram_write_port;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        ce_6mn    = 1'b0;
    logic        slot_free = 1'b0;
    logic [18:0] cpu_addr  = '0;
    logic [7:0]  cpu_din   = '0;
    logic        cpu_we    = 1'b0;
    logic        cpu_rd    = 1'b0;
    logic        cpu_wait;
    logic        fwd_hit;
    logic [7:0]  fwd_data;
    logic [18:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_ack  = 1'b0;
    logic        ovf;

    int passed = 0;
    int total  = 0;

    // slot_mode: 0 = no CPU slots, 1 = every ce_6mn is a slot, 2 = every 8th ce_6mn
    int       slot_mode = 0;
    logic [1:0] ce_cnt  = 2'd0;
    int       ce_num    = 0;

    vram_write_port #(.DEPTH(4), .AW(19)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_6mn     (ce_6mn),
        .slot_free  (slot_free),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_we     (cpu_we),
        .cpu_rd     (cpu_rd),
        .cpu_wait   (cpu_wait),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_ack   (vram_ack),
        .ovf        (ovf)
    );

    always #5 clk_sys = ~clk_sys;

    // 6 MHz enable every 4th clk_sys, with slot_free following the selected pattern.
    always @(negedge clk_sys) begin
        ce_cnt = ce_cnt + 2'd1;
        ce_6mn = (ce_cnt == 2'd0);
        if (ce_6mn) ce_num++;
        case (slot_mode)
            1:       slot_free = 1'b1;
            2:       slot_free = ce_6mn && ((ce_num % 8) == 0);
            default: slot_free = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic [18:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        @(negedge clk_sys);
        cpu_we   = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic wait_we(input string tag);
        int n = 0;
        while (vram_we !== 1'b1 && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, 32'(vram_we), 32'd1);
    endtask

    task automatic commit(input logic [18:0] a, input logic [7:0] d, input string tag);
        wait_we({tag, "_we"});
        check({tag, "_addr"}, 32'(vram_waddr), 32'(a));
        check({tag, "_data"}, 32'(vram_wdata), 32'(d));
        vram_ack = 1'b1;
        @(negedge clk_sys);
        vram_ack = 1'b0;
        check({tag, "_we_drop"}, 32'(vram_we), 32'd0);
    endtask

    initial begin
        int        n;
        int        rises;
        logic      prev_we;
        logic      stable;
        logic [18:0] a_hold;
        logic [7:0]  d_hold;

        // 1: reset values, then no slots means no writes
        repeat (3) @(negedge clk_sys);
        check("rst_we",       32'(vram_we),    32'd0);
        check("rst_waddr",    32'(vram_waddr), 32'd0);
        check("rst_wdata",    32'(vram_wdata), 32'd0);
        check("rst_wait",     32'(cpu_wait),   32'd0);
        check("rst_fwd_hit",  32'(fwd_hit),    32'd0);
        check("rst_fwd_data", 32'(fwd_data),   32'd0);
        check("rst_ovf",      32'(ovf),        32'd0);
        check("rst_count",    32'(dut.u_fifo.count), 32'd0);
        reset_n = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (vram_we === 1'b1) n++;
        end
        check("idle_no_we", 32'(n), 32'd0);

        // 2: single write, sparse slots, held until ack, exactly once
        slot_mode = 2;
        push(19'h1C000, 8'hA5);
        wait_we("single_we");
        check("single_addr", 32'(vram_waddr), 32'h1C000);
        check("single_data", 32'(vram_wdata), 32'hA5);
        repeat (3) @(negedge clk_sys);
        check("single_hold_we",   32'(vram_we),    32'd1);
        check("single_hold_addr", 32'(vram_waddr), 32'h1C000);
        vram_ack = 1'b1;
        @(negedge clk_sys);
        vram_ack = 1'b0;
        check("single_we_drop", 32'(vram_we), 32'd0);
        check("single_empty",   32'(dut.u_fifo.count), 32'd0);
        rises = 0;
        prev_we = vram_we;
        repeat (100) begin
            @(negedge clk_sys);
            if (vram_we === 1'b1 && prev_we === 1'b0) rises++;
            prev_we = vram_we;
        end
        check("single_once", 32'(rises), 32'd0);

        // 3: fill, overflow, then drain in order
        slot_mode = 0;
        for (int i = 0; i < 4; i++) push(19'h00010 + 19'(i), 8'h40 + 8'(i));
        check("fill_wait", 32'(cpu_wait), 32'd1);
        check("fill_ovf0", 32'(ovf),      32'd0);
        push(19'h00020, 8'h99);
        check("fill_ovf1",  32'(ovf), 32'd1);
        check("fill_count", 32'(dut.u_fifo.count), 32'd4);
        slot_mode = 1;
        commit(19'h00010, 8'h40, "drain0");
        check("drain_wait_fall", 32'(cpu_wait), 32'd0);
        commit(19'h00011, 8'h41, "drain1");
        commit(19'h00012, 8'h42, "drain2");
        commit(19'h00013, 8'h43, "drain3");
        slot_mode = 0;
        repeat (20) @(negedge clk_sys);
        check("drain_empty", 32'(dut.u_fifo.count), 32'd0);
        check("drain_no_we", 32'(vram_we), 32'd0);
        check("ovf_sticky",  32'(ovf), 32'd1);

        // 4: forwarding, youngest match wins
        push(19'h00100, 8'h11);
        push(19'h00100, 8'h22);
        cpu_addr = 19'h00100;
        cpu_rd = 1'b1;
        #1;
        check("fwd_hit",   32'(fwd_hit),  32'd1);
        check("fwd_data",  32'(fwd_data), 32'h22);
        cpu_addr = 19'h00101;
        #1;
        check("fwd_miss_hit",  32'(fwd_hit),  32'd0);
        check("fwd_miss_data", 32'(fwd_data), 32'd0);
        cpu_addr = 19'h00100;
        cpu_rd = 1'b0;
        #1;
        check("fwd_nord", 32'(fwd_hit), 32'd0);
        slot_mode = 1;
        wait_we("fwd_req_we");
        cpu_rd = 1'b1;
        #1;
        check("fwd_req_hit",  32'(fwd_hit),  32'd1);
        check("fwd_req_data", 32'(fwd_data), 32'h22);
        cpu_rd = 1'b0;
        commit(19'h00100, 8'h11, "fwd_c0");
        commit(19'h00100, 8'h22, "fwd_c1");
        slot_mode = 0;

        // 5: ack stall, outputs stable, one commit per slot
        push(19'h00200, 8'h5A);
        push(19'h00201, 8'h5B);
        slot_mode = 1;
        wait_we("stall_we");
        a_hold = vram_waddr;
        d_hold = vram_wdata;
        check("stall_addr", 32'(a_hold), 32'h00200);
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk_sys);
            if (vram_we !== 1'b1 || vram_waddr !== a_hold || vram_wdata !== d_hold) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        vram_ack = 1'b1;
        @(negedge clk_sys);
        vram_ack = 1'b0;
        check("stall_we_drop", 32'(vram_we), 32'd0);
        n = 0;
        while (vram_we !== 1'b1 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("slot_gap", 32'(n >= 4), 32'd1);
        commit(19'h00201, 8'h5B, "stall_c1");
        slot_mode = 0;

        // 6: reset while a request is outstanding
        push(19'h00300, 8'h77);
        slot_mode = 1;
        wait_we("rreq_we");
        #2;
        reset_n = 1'b0;
        #1;
        check("rreq_we_async", 32'(vram_we), 32'd0);
        check("rreq_count",    32'(dut.u_fifo.count), 32'd0);
        check("rreq_ovf",      32'(ovf), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        n = 0;
        repeat (50) begin
            @(negedge clk_sys);
            if (vram_we === 1'b1) n++;
        end
        check("rreq_no_reissue", 32'(n), 32'd0);
        check("rreq_empty",      32'(dut.u_fifo.count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
